// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 constants for the front end (fetch, decode).
//   XLEN / ILEN : address and instruction widths
//   RESET_PC    : default first fetch address
//   NOP         : canonical addi x0,x0,0 encoding
//   align_word  : clears the byte offset of an address
package rv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, registered storage, no bypass.
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : write request and data (ignored when full unless popping)
//   pop               : consume head (ignored when empty)
//   flush             : empties the FIFO; wins over push/pop in the same cycle
//   head_data         : head entry, forced to zero while empty
//   full, empty, count: occupancy status
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);

  // Zero while empty so downstream sees a clean value rather than stale storage.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues word reads to
// imem under a credit limit and buffers returned words for the decoder.
//   clk, rst                         : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        : imem read request channel
//   imem_rsp_valid/data              : in-order imem responses, no back-pressure
//   redirect_valid/pc                : single-cycle restart from execute
//   instr_valid/ready, instr/instr_pc: handshake to the decoder
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]      fetch_pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        fifo_count;
  logic                 req_fire;
  logic                 rsp;
  logic                 drop_rsp;
  logic                 data_push;
  logic                 data_pop;
  logic                 data_full;
  logic                 data_empty;
  logic [ILEN+XLEN-1:0] data_head;
  logic [XLEN-1:0]      pcq_head;
  logic                 pcq_full;
  logic                 pcq_empty;
  logic [CW-1:0]        pcq_count;
  logic                 unused_fifo_status;

  // Every request in flight owns a FIFO slot, so responses never need
  // back-pressure.
  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp            = imem_rsp_valid;
  assign drop_rsp       = (drop_cnt != '0);

  // A response landing in a redirect cycle is stale by definition.
  assign data_push = rsp && !drop_rsp && !redirect_valid;
  assign data_pop  = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = !data_empty;
  assign instr       = data_head[ILEN+XLEN-1:XLEN];
  assign instr_pc    = data_head[XLEN-1:0];

  assign unused_fifo_status = ^{data_full, pcq_full, pcq_empty, pcq_count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // No request fires this cycle; all remaining in-flight words are stale.
      fetch_pc    <= align_word(redirect_pc);
      outstanding <= outstanding - CW'(rsp);
      drop_cnt    <= outstanding - CW'(rsp);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp);
      if (rsp && drop_rsp) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .WIDTH(ILEN + XLEN),
    .DEPTH(DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (data_push),
    .push_data ({imem_rsp_data, pcq_head}),
    .pop       (data_pop),
    .flush     (redirect_valid),
    .head_data (data_head),
    .full      (data_full),
    .empty     (data_empty),
    .count     (fifo_count)
  );

  // Request PCs ride alongside in-flight requests; never flushed, since stale
  // entries drain one-for-one with the dropped responses.
  fetch_fifo #(
    .WIDTH(XLEN),
    .DEPTH(DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp),
    .flush     (1'b0),
    .head_data (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// The reference model tags each imem request with a redirect epoch; only
// responses from the current epoch are expected at the decoder, in order.
module tb_fetch_unit;
  import rv_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          epoch;
    longint      due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } item_t;

  req_t        pend[$];
  item_t       exp_q[$];
  logic [31:0] exp_req_pc;
  int          epoch;
  longint      cyc;
  longint      last_due;
  int          lat_min, lat_max, p_req_ready, p_instr_ready;
  int          checks, errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached within cycle budget (t=%0t)", name, $time);
  endtask

  task automatic model_clear(input logic [31:0] start_pc);
    exp_q.delete();
    epoch++;
    exp_req_pc = start_pc;
  endtask

  // One clock: drive at negedge, observe request fire, update model after posedge.
  task automatic step(input logic redir, input logic [31:0] rpc);
    logic  rsp_now, fire;
    logic  [31:0] issue_addr;
    req_t  r;
    longint due;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < p_req_ready);
    instr_ready    = ($urandom_range(99) < p_instr_ready);
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp_now        = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(pend[0].addr) : $urandom();
    #1;
    fire       = imem_req_valid && imem_req_ready;
    issue_addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (rsp_now) begin
      r = pend.pop_front();
      if (r.epoch == epoch && !redir) exp_q.push_back('{pc: r.pc, data: mem_word(r.pc)});
    end
    if (redir) model_clear(align_word(rpc));
    if (fire) begin
      due = cyc + longint'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: issue_addr, pc: exp_req_pc, epoch: epoch, due: due});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    pend.delete();
    model_clear(RPC);
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int prr, input int pir);
    lat_min = lmin; lat_max = lmax; p_req_ready = prr; p_instr_ready = pir;
  endtask

  // Monitor: compares DUT outputs against the model just before each posedge.
  always begin
    int stale;
    @(negedge clk);
    #3;
    if (rst) begin
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
    end else begin
      chk("req_valid", 32'(imem_req_valid),
          32'(!redirect_valid && (exp_q.size() + pend.size() < DEPTH)));
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req_pc);
      chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (instr_valid && exp_q.size() > 0) begin
        chk("instr_pc", instr_pc, exp_q[0].pc);
        chk("instr", instr, exp_q[0].data);
        if (instr_ready && !redirect_valid) void'(exp_q.pop_front());
      end
      stale = 0;
      foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
      chk("outstanding", 32'(dut.outstanding), 32'(pend.size()));
      chk("drop_cnt", 32'(dut.drop_cnt), 32'(stale));
      chk("inv_drop_le_out", 32'(dut.drop_cnt <= dut.outstanding), 32'd1);
      chk("inv_credit", 32'(32'(dut.fifo_count) + 32'(dut.outstanding) <= DEPTH), 32'd1);
      chk("inv_no_push_full", 32'(dut.data_push && dut.data_full), 32'd0);
    end
  end

  initial begin
    int n;
    logic [31:0] tgt;
    checks = 0; errors = 0; epoch = 0; cyc = 0; last_due = -1;
    exp_req_pc = RPC;
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    set_knobs(1, 1, 100, 100);
    do_reset(2);

    // Streaming with 1-cycle imem.
    run(10);

    // Decoder stalled: credits run out, then resume without loss.
    do_reset(1);
    set_knobs(1, 1, 100, 0);
    run(8);
    p_instr_ready = 100;
    run(8);

    // Redirect with two requests in flight, latency 3.
    set_knobs(3, 3, 100, 100);
    n = 0;
    while (pend.size() != 2 && n < 50) begin step(1'b0, 0); n++; end
    if (pend.size() != 2) timeout_fail("wait_two_outstanding");
    step(1'b1, 32'h100);
    run(12);

    // Redirect coinciding with a response.
    set_knobs(2, 2, 100, 100);
    n = 0;
    while (!(pend.size() > 0 && pend[0].due <= cyc) && n < 50) begin step(1'b0, 0); n++; end
    if (!(pend.size() > 0 && pend[0].due <= cyc)) timeout_fail("wait_rsp_cycle");
    step(1'b1, 32'h300);
    run(10);

    // Misaligned target and back-to-back redirects.
    step(1'b1, 32'h203);
    run(8);
    step(1'b1, 32'h40);
    step(1'b1, 32'h80);
    run(10);

    // Reset with one word buffered and one request in flight.
    do_reset(1);
    set_knobs(3, 3, 100, 0);
    n = 0;
    while (!(exp_q.size() == 1 && pend.size() == 1) && n < 50) begin step(1'b0, 0); n++; end
    if (!(exp_q.size() == 1 && pend.size() == 1)) timeout_fail("wait_buffered_inflight");
    do_reset(2);
    set_knobs(1, 2, 100, 100);
    run(10);

    // Randomized traffic with redirects (including PC wrap) and rare resets.
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0)
        set_knobs(1, $urandom_range(4, 1), $urandom_range(100, 30), $urandom_range(100, 20));
      if ($urandom_range(999) < 4) begin
        do_reset($urandom_range(2, 1));
      end else if ($urandom_range(99) < 3) begin
        tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
        step(1'b1, tgt);
      end else begin
        step(1'b0, 32'h0);
      end
    end
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
